seven_segment_scan_controller: RTL and testbench

- Time-multiplexes one shared active-low 7-segment decoder across DIGITS common-anode digits of the house-light status display.
- Each cycle it drives the 4-bit digit value into the decoder's num input and enables exactly one digit anode (active-low).
- Inserts a dead-time gap between digits to prevent ghosting.
- Double-buffers host-written values so a frame is never torn, and supports leading-zero and per-digit blanking.

---
 rtl/seven_seg_scan_pkg.sv | 24 ++
 rtl/seven_segment_scan_timer.sv | 29 ++
 rtl/seven_segment_scan_controller.sv | 151 +++++++++++++++
 tb/tb_seven_segment_scan_controller.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_scan_pkg.sv
// Shared types and helpers for the multiplexed 7-segment scan controller.
// The leading-zero test works on a fixed-width digit vector so any DIGITS up to MAX_DIGITS fits.
package seven_seg_scan_pkg;

  typedef enum logic {S_GAP, S_SHOW} state_e;

  localparam int DIGIT_W    = 4;
  localparam int MAX_DIGITS = 16;

  // Digit i is a leading zero when it and every more-significant digit are zero.
  // Unused upper digits must be zero-filled by the caller.
  function automatic logic lz_blanked(input logic [DIGIT_W*MAX_DIGITS-1:0] active,
                                      input int i);
    logic all_zero;
    all_zero = 1'b1;
    for (int j = 0; j < MAX_DIGITS; j++) begin
      if (j >= i && active[j*DIGIT_W +: DIGIT_W] != '0) begin
        all_zero = 1'b0;
      end
    end
    return (i != 0) && all_zero;
  endfunction

endpackage

// File: rtl/seven_segment_scan_timer.sv
// Up-counter that restarts on clear_i and flags when it sits on the terminal count term_i.
module seven_segment_scan_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear_i,
  input  logic [W-1:0] term_i,
  output logic         done_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = clear_i ? '0 : count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = (count_q == term_i);

endmodule

// File: rtl/seven_segment_scan_controller.sv
// Scans DIGITS common-anode digits through one shared decoder, with dead-time gaps,
// a frame-aligned double buffer for host values, and per-digit / leading-zero blanking.
module seven_segment_scan_controller
  import seven_seg_scan_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int DWELL  = 50000,
  parameter int GAP    = 500
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load,
  input  logic [DIGIT_W*DIGITS-1:0] value_in,
  input  logic [DIGITS-1:0]         blank_mask,
  input  logic                      lz_blank,
  output logic [DIGIT_W-1:0]        num,
  output logic [DIGITS-1:0]         digit_an_n,
  output logic                      frame_tick
);

  localparam int TMAX_DG = (DWELL > GAP) ? DWELL : GAP;
  localparam int TMAX    = (TMAX_DG > 2) ? TMAX_DG : 2;
  localparam int TW      = $clog2(TMAX);
  localparam int IW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [TW-1:0] TERM_SHOW = TW'(DWELL - 1);
  localparam logic [TW-1:0] TERM_GAP  = TW'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [IW-1:0] LAST_IDX  = IW'(DIGITS - 1);

  state_e                    state_q, state_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [DIGIT_W*DIGITS-1:0] pending_q, pending_d;
  logic [DIGIT_W*DIGITS-1:0] active_q, active_d;
  logic                      pend_valid_q, pend_valid_d;
  logic [DIGIT_W-1:0]        num_q, num_d;
  logic [DIGITS-1:0]         an_q, an_d;
  logic                      tick_q, tick_d;

  logic                          show_entry;
  logic                          timer_clear;
  logic                          timer_done;
  logic [TW-1:0]                 timer_term;
  logic [DIGIT_W*MAX_DIGITS-1:0] active_ext;
  logic                          digit_blank;

  assign timer_term  = (state_q == S_SHOW) ? TERM_SHOW : TERM_GAP;
  assign timer_clear = show_entry || (state_d != state_q);

  seven_segment_scan_timer #(
    .W (TW)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (timer_clear),
    .term_i  (timer_term),
    .done_o  (timer_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_GAP;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // With GAP=0 a finished dwell re-enters SHOW directly on the next digit.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    show_entry = 1'b0;
    case (state_q)
      S_GAP: begin
        if (GAP == 0 || timer_done) begin
          state_d    = S_SHOW;
          show_entry = 1'b1;
        end
      end
      S_SHOW: begin
        if (timer_done) begin
          idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
          if (GAP == 0) begin
            show_entry = 1'b1;
          end else begin
            state_d = S_GAP;
          end
        end
      end
      default: state_d = S_GAP;
    endcase
  end

  always_comb begin
    pending_d    = pending_q;
    pend_valid_d = pend_valid_q;
    active_d     = active_q;
    num_d        = num_q;
    an_d         = an_q;
    tick_d       = 1'b0;
    active_ext   = '0;

    // Frame swap uses the old pending value; a same-cycle load refills it below.
    if (show_entry && idx_d == '0 && pend_valid_q) begin
      active_d     = pending_q;
      pend_valid_d = 1'b0;
    end
    if (load) begin
      pending_d    = value_in;
      pend_valid_d = 1'b1;
    end

    active_ext[DIGIT_W*DIGITS-1:0] = active_d;
    digit_blank = blank_mask[idx_d] | (lz_blank & lz_blanked(active_ext, int'(idx_d)));

    if (show_entry) begin
      num_d  = active_d[idx_d*DIGIT_W +: DIGIT_W];
      an_d   = '1;
      if (!digit_blank) begin
        an_d[idx_d] = 1'b0;
      end
      tick_d = (idx_d == '0);
    end else if (state_q == S_SHOW && state_d == S_GAP) begin
      an_d = '1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q    <= '0;
      pend_valid_q <= 1'b0;
      active_q     <= '0;
      num_q        <= '0;
      an_q         <= '1;
      tick_q       <= 1'b0;
    end else begin
      pending_q    <= pending_d;
      pend_valid_q <= pend_valid_d;
      active_q     <= active_d;
      num_q        <= num_d;
      an_q         <= an_d;
      tick_q       <= tick_d;
    end
  end

  assign num        = num_q;
  assign digit_an_n = an_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// Two controllers (GAP=1 and GAP=0) against a slot-arithmetic model plus hand-computed checkpoints.
module tb_seven_segment_scan_controller;

  localparam int DIGITS = 4;
  localparam int DWELL  = 4;
  localparam int GAP_A  = 1;
  localparam int GAP_B  = 0;
  localparam int NCFG   = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load = 1'b0;
  logic [15:0] value_in = '0;
  logic [3:0]  blank_mask = '0;
  logic        lz_blank = 1'b0;

  logic [3:0] num_a, an_a, num_b, an_b;
  logic       tick_a, tick_b;

  int errors = 0;
  int checks = 0;
  bit checking = 1'b0;

  always #5 clk = ~clk;

  seven_segment_scan_controller #(.DIGITS(DIGITS), .DWELL(DWELL), .GAP(GAP_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .load(load), .value_in(value_in), .blank_mask(blank_mask),
    .lz_blank(lz_blank), .num(num_a), .digit_an_n(an_a), .frame_tick(tick_a)
  );

  seven_segment_scan_controller #(.DIGITS(DIGITS), .DWELL(DWELL), .GAP(GAP_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .load(load), .value_in(value_in), .blank_mask(blank_mask),
    .lz_blank(lz_blank), .num(num_b), .digit_an_n(an_b), .frame_tick(tick_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask

  // Model: edges since reset release decide slot, digit and offset by plain arithmetic.
  int n;
  int m_active  [NCFG][DIGITS];
  int m_pending [NCFG][DIGITS];
  bit m_pv      [NCFG];
  int e_num     [NCFG];
  int e_an      [NCFG];
  int e_tick    [NCFG];
  int g, first, per, k, d, off;
  bit bl, zero_run;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n = 0;
      for (int c = 0; c < NCFG; c++) begin
        for (int i = 0; i < DIGITS; i++) begin
          m_active[c][i]  = 0;
          m_pending[c][i] = 0;
        end
        m_pv[c]   = 1'b0;
        e_num[c]  = 0;
        e_an[c]   = 15;
        e_tick[c] = 0;
      end
    end else begin
      n++;
      for (int c = 0; c < NCFG; c++) begin
        g     = (c == 0) ? GAP_A : GAP_B;
        first = (g > 0) ? g : 1;
        per   = DWELL + g;
        e_tick[c] = 0;
        if (n >= first) begin
          k   = n - first;
          d   = (k / per) % DIGITS;
          off = k % per;
          if (off == 0) begin
            if (d == 0 && m_pv[c]) begin
              for (int i = 0; i < DIGITS; i++) m_active[c][i] = m_pending[c][i];
              m_pv[c] = 1'b0;
            end
            bl = blank_mask[d];
            if (lz_blank && d != 0) begin
              zero_run = 1'b1;
              for (int j = d; j < DIGITS; j++) if (m_active[c][j] != 0) zero_run = 1'b0;
              if (zero_run) bl = 1'b1;
            end
            e_num[c]  = m_active[c][d];
            e_an[c]   = bl ? 15 : (15 & ~(1 << d));
            e_tick[c] = (d == 0) ? 1 : 0;
          end else if (off == DWELL) begin
            e_an[c] = 15;
          end
        end
        if (load) begin
          for (int i = 0; i < DIGITS; i++) m_pending[c][i] = int'(value_in[4*i +: 4]);
          m_pv[c] = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("model_an_gap1",   32'(an_a),   32'(e_an[0]));
      chk("model_num_gap1",  32'(num_a),  32'(e_num[0]));
      chk("model_tick_gap1", 32'(tick_a), 32'(e_tick[0]));
      chk("model_an_gap0",   32'(an_b),   32'(e_an[1]));
      chk("model_num_gap0",  32'(num_b),  32'(e_num[1]));
      chk("model_tick_gap0", 32'(tick_b), 32'(e_tick[1]));
    end
  end

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    step(3);
    checking = 1'b1;
    step(1);
    rst_n = 1'b1;                                   // edge count 0
    chk("reset_an", 32'(an_a), 32'hF);
    chk("reset_num", 32'(num_a), 32'h0);
    chk("reset_tick", 32'(tick_a), 32'h0);
    step(1);                                        // 1
    chk("first_show_an", 32'(an_a), 32'hE);
    chk("first_tick", 32'(tick_a), 32'h1);
    chk("first_num", 32'(num_a), 32'h0);
    chk("gap0_first_an", 32'(an_b), 32'hE);
    step(1);                                        // 2
    chk("tick_one_clk", 32'(tick_a), 32'h0);
    step(2);                                        // 4
    chk("dwell_last_an", 32'(an_a), 32'hE);
    chk("gap0_dwell_last", 32'(an_b), 32'hE);
    step(1);                                        // 5
    chk("gap_all_high", 32'(an_a), 32'hF);
    chk("gap0_no_gap", 32'(an_b), 32'hD);
    step(1);                                        // 6
    chk("digit1_an", 32'(an_a), 32'hD);
    step(2);                                        // 8
    load = 1'b1; value_in = 16'h1234;
    step(1);                                        // 9
    load = 1'b0;
    step(2);                                        // 11
    chk("no_tear_num", 32'(num_a), 32'h0);
    step(6);                                        // 17
    chk("gap0_period16", 32'(tick_b), 32'h1);
    step(4);                                        // 21
    chk("frame_tick_20", 32'(tick_a), 32'h1);
    chk("load_num_d0", 32'(num_a), 32'h4);
    step(5);                                        // 26
    chk("load_num_d1", 32'(num_a), 32'h3);
    step(5);                                        // 31
    chk("load_num_d2", 32'(num_a), 32'h2);
    step(5);                                        // 36
    chk("load_num_d3", 32'(num_a), 32'h1);
    chk("digit3_an", 32'(an_a), 32'h7);
    step(2);                                        // 38
    load = 1'b1; value_in = 16'h0007; lz_blank = 1'b1;
    step(1);                                        // 39
    load = 1'b0;
    step(2);                                        // 41
    chk("lz_d0_num", 32'(num_a), 32'h7);
    chk("lz_d0_an", 32'(an_a), 32'hE);
    step(5);                                        // 46
    chk("lz_d1_dark", 32'(an_a), 32'hF);
    step(15);                                       // 61
    chk("lz_period", 32'(tick_a), 32'h1);
    step(8);                                        // 69
    load = 1'b1; value_in = 16'h1111; lz_blank = 1'b0;
    step(1);                                        // 70
    load = 1'b0;
    step(10);                                       // 80
    load = 1'b1; value_in = 16'hA5A5;
    step(1);                                        // 81: copy edge
    load = 1'b0;
    chk("coincide_old_num", 32'(num_a), 32'h1);
    chk("coincide_tick", 32'(tick_a), 32'h1);
    step(20);                                       // 101
    chk("coincide_next_num", 32'(num_a), 32'h5);
    step(2);                                        // 103
    blank_mask = 4'b0010;
    step(3);                                        // 106
    chk("mask_d1_dark", 32'(an_a), 32'hF);
    chk("mask_d1_num", 32'(num_a), 32'hA);
    step(5);                                        // 111
    chk("mask_d2_lit", 32'(an_a), 32'hB);
    blank_mask = 4'b0000;
    step(1);                                        // 112, mid-dwell of digit 2
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_an", 32'(an_a), 32'hF);
    chk("async_rst_num", 32'(num_a), 32'h0);
    step(2);
    rst_n = 1'b1;
    chk("rerelease_an", 32'(an_a), 32'hF);
    step(1);
    chk("restart_an", 32'(an_a), 32'hE);
    chk("restart_num", 32'(num_a), 32'h0);
    chk("restart_tick", 32'(tick_a), 32'h1);
    step(40);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
